// File: rtl/ukucorn_pkg.sv
// Shared types and helpers for the FFT peak finder: FSM states, complex word layout, squared magnitude.
package ukucorn_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} finder_state_t;

  localparam int RE_MSB = 31;
  localparam int IM_MSB = 15;
  localparam int HALF_W = 16;
  localparam int MAG_W  = 32;

  // Worst case (-1.0)^2 + (-1.0)^2 = 2^31, so an unsigned 32-bit sum never wraps.
  function automatic logic [MAG_W-1:0] sq_mag(input logic signed [HALF_W-1:0] re,
                                              input logic signed [HALF_W-1:0] im);
    logic signed [MAG_W-1:0] rr;
    logic signed [MAG_W-1:0] ii;
    rr = re * re;
    ii = im * im;
    return $unsigned(rr) + $unsigned(ii);
  endfunction

endpackage

// File: rtl/fft_peak_finder_peak_sorter.sv
// K-slot insertion register holding the strongest bins in descending magnitude order.
// One-cycle update; clear wins over a simultaneous insert.
module peak_sorter
  import ukucorn_pkg::*;
#(
  parameter int K  = 4,
  parameter int BW = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [MAG_W-1:0]      in_mag,
  input  logic [BW-1:0]         in_bin,
  output logic [K-1:0][BW-1:0]  slot_bin,
  output logic [K-1:0]          slot_valid
);

  logic [K-1:0][MAG_W-1:0] mag_q, mag_d;
  logic [K-1:0][BW-1:0]    bin_q, bin_d;
  logic [K-1:0]            vld_q, vld_d;
  logic [K-1:0]            gt;

  // Slots are sorted and empties hold 0, so gt is a thermometer: once set it stays set downward.
  always_comb begin
    mag_d = mag_q;
    bin_d = bin_q;
    vld_d = vld_q;
    for (int j = 0; j < K; j++) gt[j] = in_mag > mag_q[j];
    if (clear) begin
      mag_d = '0;
      bin_d = '0;
      vld_d = '0;
    end else if (in_valid) begin
      if (gt[0]) begin
        mag_d[0] = in_mag;
        bin_d[0] = in_bin;
        vld_d[0] = 1'b1;
      end
      for (int j = 1; j < K; j++) begin
        if (gt[j-1]) begin
          mag_d[j] = mag_q[j-1];
          bin_d[j] = bin_q[j-1];
          vld_d[j] = vld_q[j-1];
        end else if (gt[j]) begin
          mag_d[j] = in_mag;
          bin_d[j] = in_bin;
          vld_d[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_q <= '0;
      bin_q <= '0;
      vld_q <= '0;
    end else begin
      mag_q <= mag_d;
      bin_q <= bin_d;
      vld_q <= vld_d;
    end
  end

  assign slot_bin   = bin_q;
  assign slot_valid = vld_q;

endmodule

// File: rtl/fft_peak_finder.sv
// Scans FFT result bins 1..N/2-1 from the RAM read port and keeps the four strongest by |X|^2.
// Address to sorter update is 3 cycles; done rises N/2+2 edges after the accepted start.
module fft_peak_finder
  import ukucorn_pkg::*;
#(
  parameter int          logN    = 9,
  parameter logic [31:0] MIN_MAG = 32'd0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            rd_en,
  output logic [logN-1:0] rd_addr,
  input  logic [31:0]     rd_data,
  output logic            busy,
  output logic            done,
  output logic [logN-2:0] peak_bin0,
  output logic [logN-2:0] peak_bin1,
  output logic [logN-2:0] peak_bin2,
  output logic [logN-2:0] peak_bin3,
  output logic [3:0]      peak_valid
);

  localparam int              BW        = logN - 1;
  localparam logic [logN-1:0] LAST_ADDR = {1'b0, {BW{1'b1}}};
  localparam logic [BW-1:0]   LAST_BIN  = {BW{1'b1}};

  finder_state_t         state_q, state_d;
  logic [logN-1:0]       addr_q, addr_d;
  logic                  rd_en_q, rd_en_d;
  logic                  clear;
  logic                  v1_q, v2_q;
  logic [BW-1:0]         bin1_q, bin2_q;
  logic [MAG_W-1:0]      mag_q;
  logic [3:0][BW-1:0]    slot_bin;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_en_d = rd_en_q;
    clear   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SCAN;
          clear   = 1'b1;
        end
      end
      SCAN: begin
        if (!rd_en_q) begin
          rd_en_d = 1'b1;
          addr_d  = {{BW{1'b0}}, 1'b1};
        end else if (addr_q == LAST_ADDR) begin
          rd_en_d = 1'b0;
          addr_d  = '0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      // Leave once the last bin's magnitude is presented; the sorter absorbs it on the same edge.
      DRAIN: begin
        if (v2_q && bin2_q == LAST_BIN) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      bin1_q <= '0;
      bin2_q <= '0;
      mag_q  <= '0;
    end else begin
      v1_q   <= rd_en_q;
      bin1_q <= addr_q[BW-1:0];
      v2_q   <= v1_q;
      bin2_q <= bin1_q;
      if (v1_q) mag_q <= sq_mag(rd_data[RE_MSB -: HALF_W], rd_data[IM_MSB -: HALF_W]);
    end
  end

  peak_sorter #(.K(4), .BW(BW)) u_sorter (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (v2_q && (mag_q > MIN_MAG)),
    .in_mag     (mag_q),
    .in_bin     (bin2_q),
    .slot_bin   (slot_bin),
    .slot_valid (peak_valid)
  );

  assign rd_en     = rd_en_q;
  assign rd_addr   = addr_q;
  assign busy      = (state_q == SCAN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign peak_bin0 = slot_bin[0];
  assign peak_bin1 = slot_bin[1];
  assign peak_bin2 = slot_bin[2];
  assign peak_bin3 = slot_bin[3];

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed bench for fft_peak_finder: N=16 table vectors, N=512 full-scale scan, reset abort, MIN_MAG floor.
module tb_fft_peak_finder;

  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b, start_c;
  always #5 clk = ~clk;

  logic        rd_en_a, busy_a, done_a;
  logic [3:0]  rd_addr_a, pv_a;
  logic [31:0] rd_data_a;
  logic [2:0]  pb0_a, pb1_a, pb2_a, pb3_a;

  logic        rd_en_c, busy_c, done_c;
  logic [3:0]  rd_addr_c, pv_c;
  logic [31:0] rd_data_c;
  logic [2:0]  pb0_c, pb1_c, pb2_c, pb3_c;

  logic        rd_en_b, busy_b, done_b;
  logic [8:0]  rd_addr_b;
  logic [3:0]  pv_b;
  logic [31:0] rd_data_b;
  logic [7:0]  pb0_b, pb1_b, pb2_b, pb3_b;

  logic [31:0] mem4 [0:15];
  logic [31:0] mem_b [0:511];

  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem4[rd_addr_a];
    if (rd_en_c) rd_data_c <= mem4[rd_addr_c];
    if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
  end

  fft_peak_finder #(.logN(4), .MIN_MAG(32'd0)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .busy(busy_a), .done(done_a), .peak_bin0(pb0_a), .peak_bin1(pb1_a),
    .peak_bin2(pb2_a), .peak_bin3(pb3_a), .peak_valid(pv_a));

  fft_peak_finder #(.logN(4), .MIN_MAG(32'd100)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .rd_en(rd_en_c), .rd_addr(rd_addr_c),
    .rd_data(rd_data_c), .busy(busy_c), .done(done_c), .peak_bin0(pb0_c), .peak_bin1(pb1_c),
    .peak_bin2(pb2_c), .peak_bin3(pb3_c), .peak_valid(pv_c));

  fft_peak_finder #(.logN(9), .MIN_MAG(32'd0)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .busy(busy_b), .done(done_b), .peak_bin0(pb0_b), .peak_bin1(pb1_b),
    .peak_bin2(pb2_b), .peak_bin3(pb3_b), .peak_valid(pv_b));

  typedef struct packed {
    logic [6:0][31:0] w;
    logic [3:0][2:0]  eb;
    logic [3:0]       ev;
    logic             glitch;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t vecs [7];

  function automatic vec_t mk(input logic [31:0] b1, input logic [31:0] b2, input logic [31:0] b3,
                              input logic [31:0] b4, input logic [31:0] b5, input logic [31:0] b6,
                              input logic [31:0] b7, input int e0, input int e1, input int e2,
                              input int e3, input logic [3:0] ev, input logic g);
    vec_t v;
    v.w      = {b7, b6, b5, b4, b3, b2, b1};
    v.eb     = {3'(e3), 3'(e2), 3'(e1), 3'(e0)};
    v.ev     = ev;
    v.glitch = g;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic sample(input logic use_c, output logic en, output logic [3:0] ad, output logic bz,
                        output logic dn, output logic [3:0] pv, output logic [3:0][2:0] pb);
    en = use_c ? rd_en_c : rd_en_a;
    ad = use_c ? rd_addr_c : rd_addr_a;
    bz = use_c ? busy_c : busy_a;
    dn = use_c ? done_c : done_a;
    pv = use_c ? pv_c : pv_a;
    pb = use_c ? {pb3_c, pb2_c, pb1_c, pb0_c} : {pb3_a, pb2_a, pb1_a, pb0_a};
  endtask

  // One N=16 scan: start at edge E0, addresses 1..7 after E1..E7, done after E10.
  task automatic run4(input logic use_c, input vec_t v, input string tag);
    int done_k;
    logic seq_ok, en, bz, dn;
    logic [3:0] ad, pv;
    logic [3:0][2:0] pb;
    for (int i = 1; i <= 7; i++) mem4[i] = v.w[i-1];
    @(negedge clk);
    start_a = !use_c;
    start_c = use_c;
    @(negedge clk);
    start_a = 1'b0;
    start_c = 1'b0;
    sample(use_c, en, ad, bz, dn, pv, pb);
    check($sformatf("%s busy_after_start", tag), 32'(bz), 32'd1);
    check($sformatf("%s done_cleared", tag), 32'(dn), 32'd0);
    check($sformatf("%s valid_cleared", tag), 32'(pv), 32'd0);
    done_k = -1;
    seq_ok = (en === 1'b0) && (ad === 4'd0);
    for (int k = 1; k <= 40 && done_k < 0; k++) begin
      @(negedge clk);
      sample(use_c, en, ad, bz, dn, pv, pb);
      if (en !== (k <= 7) || ad !== ((k <= 7) ? 4'(k) : 4'd0)) seq_ok = 1'b0;
      if (dn) done_k = k;
      start_a = !use_c && v.glitch && (k == 3 || k == 8 || k == 9);
      start_c = use_c && v.glitch && (k == 3 || k == 8 || k == 9);
    end
    start_a = 1'b0;
    start_c = 1'b0;
    check($sformatf("%s done_edge", tag), 32'(done_k), 32'd10);
    check($sformatf("%s rd_addr_seq", tag), 32'(seq_ok), 32'd1);
    check($sformatf("%s busy_at_done", tag), 32'(bz), 32'd0);
    for (int s = 0; s < 4; s++)
      check($sformatf("%s peak_bin%0d", tag, s), 32'(pb[s]), 32'(v.eb[s]));
    check($sformatf("%s peak_valid", tag), 32'(pv), 32'(v.ev));
  endtask

  task automatic run9(input string tag);
    int done_k;
    for (int i = 0; i < 512; i++) mem_b[i] = (i == 255) ? 32'h8000_8000 : 32'h7FFF_7FFF;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    done_k = -1;
    for (int k = 1; k <= 400 && done_k < 0; k++) begin
      @(negedge clk);
      if (done_b) done_k = k;
    end
    check($sformatf("%s done_edge", tag), 32'(done_k), 32'd258);
    check($sformatf("%s peak_bin0", tag), 32'(pb0_b), 32'd255);
    check($sformatf("%s peak_bin1", tag), 32'(pb1_b), 32'd1);
    check($sformatf("%s peak_bin2", tag), 32'(pb2_b), 32'd2);
    check($sformatf("%s peak_bin3", tag), 32'(pb3_b), 32'd3);
    check($sformatf("%s peak_valid", tag), 32'(pv_b), 32'hF);
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    for (int i = 0; i < 16; i++) mem4[i] = 32'h7FFF_7FFF;

    vecs[0] = mk(0, 0, 32'h4000_0000, 0, 0, 0, 0, 3, 0, 0, 0, 4'b0001, 1'b0);
    vecs[1] = mk(32'h0005_0000, 32'h0009_0000, 32'h0002_0000, 32'h0009_0000, 32'h0007_0000,
                 32'h0001_0000, 32'h0003_0000, 2, 4, 5, 1, 4'b1111, 1'b0);
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1'b0);
    vecs[3] = mk(32'hFFFD_0004, 32'h0000_FFFA, 32'hFFFF_FFFF, 32'h0005_0000, 0,
                 32'hFFFA_0000, 32'h0002_0002, 2, 6, 1, 4, 4'b1111, 1'b0);
    vecs[4] = mk(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000,
                 32'h0006_0000, 32'h0007_0000, 7, 6, 5, 4, 4'b1111, 1'b0);
    vecs[5] = mk(32'h0005_0000, 32'h0009_0000, 32'h0002_0000, 32'h0009_0000, 32'h0007_0000,
                 32'h0001_0000, 32'h0003_0000, 2, 4, 5, 1, 4'b1111, 1'b1);
    vecs[6] = mk(0, 0, 0, 0, 32'hFFFE_0000, 0, 32'h0003_0000, 7, 5, 0, 0, 4'b0011, 1'b0);

    repeat (2) @(negedge clk);
    check("reset rd_en", 32'(rd_en_a), 32'd0);
    check("reset rd_addr", 32'(rd_addr_a), 32'd0);
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset done", 32'(done_a), 32'd0);
    check("reset peak_valid", 32'(pv_a), 32'd0);
    check("reset peak_bin0", 32'(pb0_a), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run4(1'b0, vecs[i], $sformatf("vec%0d", i));

    run4(1'b1, mk(0, 32'h000A_0000, 0, 0, 0, 32'h000A_0001, 0, 6, 0, 0, 0, 4'b0001, 1'b0),
         "min_mag");

    run9("full_scale");

    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (50) @(negedge clk);
    check("abort busy_before", 32'(busy_b), 32'd1);
    reset = 1'b1;
    #1;
    check("abort rd_en", 32'(rd_en_b), 32'd0);
    check("abort rd_addr", 32'(rd_addr_b), 32'd0);
    check("abort busy", 32'(busy_b), 32'd0);
    check("abort done", 32'(done_b), 32'd0);
    check("abort peak_valid", 32'(pv_b), 32'd0);
    check("abort peak_bin0", 32'(pb0_b), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run9("rescan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
